// File: rtl/dcache_port_arbiter_pkg.sv
// Shared types and sizing for the D-cache port arbiter and its load-slot table.
package dcache_port_arbiter_pkg;

  localparam int ADDR_W             = 32;
  localparam int MEM_SIZE_W         = 2;
  localparam int MEM_BLOCK_W        = 64;
  localparam int DC_LQ_SIZE         = 128;
  localparam int DC_LQ_IDX_W        = $clog2(DC_LQ_SIZE);
  localparam int DC_MAX_OUTSTANDING = 4;

  typedef enum logic {
    MEM_LOAD  = 1'b0,
    MEM_STORE = 1'b1
  } MEM_COMMAND;

  typedef enum logic {
    ARB_LOAD_PRI  = 1'b0,
    ARB_STORE_PRI = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic                   valid;
    logic                   squashed;
    logic [DC_LQ_IDX_W-1:0] lq_tag;
  } dc_slot_t;

endpackage

// File: rtl/dcache_port_arbiter_slot_table.sv
// Outstanding-load ID table: slot storage, lowest-free allocator and occupancy count.
module dcache_port_arbiter_slot_table
  import dcache_port_arbiter_pkg::*;
#(
  parameter int N_SLOTS = DC_MAX_OUTSTANDING
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           i_alloc,
  input  logic [DC_LQ_IDX_W-1:0]         i_alloc_tag,
  input  logic                           i_release,
  input  logic [$clog2(N_SLOTS)-1:0]     i_release_id,
  input  logic                           i_squash,
  output logic                           o_free_avail,
  output logic [$clog2(N_SLOTS)-1:0]     o_free_id,
  output logic                           o_rel_valid,
  output logic                           o_rel_squashed,
  output logic [DC_LQ_IDX_W-1:0]         o_rel_tag,
  output logic [$clog2(N_SLOTS+1)-1:0]   o_count
);

  localparam int ID_W  = $clog2(N_SLOTS);
  localparam int CNT_W = $clog2(N_SLOTS + 1);

  dc_slot_t           r_slots [N_SLOTS];
  dc_slot_t           w_next  [N_SLOTS];
  logic [CNT_W-1:0]   r_count;
  logic [CNT_W-1:0]   w_count;

  // Allocation looks only at registered state, so a slot released this cycle is not reused until next cycle.
  always_comb begin
    o_free_avail = 1'b0;
    o_free_id    = '0;
    for (int i = N_SLOTS - 1; i >= 0; i--) begin
      if (!r_slots[i].valid) begin
        o_free_avail = 1'b1;
        o_free_id    = ID_W'(i);
      end
    end
  end

  assign o_rel_valid    = r_slots[i_release_id].valid;
  assign o_rel_squashed = r_slots[i_release_id].squashed;
  assign o_rel_tag      = r_slots[i_release_id].lq_tag;
  assign o_count        = r_count;

  always_comb begin
    w_next = r_slots;
    for (int i = 0; i < N_SLOTS; i++) begin
      if (i_squash && r_slots[i].valid) w_next[i].squashed = 1'b1;
    end
    if (i_release && r_slots[i_release_id].valid) w_next[i_release_id] = '0;
    if (i_alloc) begin
      w_next[o_free_id].valid    = 1'b1;
      w_next[o_free_id].squashed = 1'b0;
      w_next[o_free_id].lq_tag   = i_alloc_tag;
    end
    w_count = '0;
    for (int i = 0; i < N_SLOTS; i++) begin
      w_count = w_count + CNT_W'(w_next[i].valid);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < N_SLOTS; i++) r_slots[i] <= '0;
      r_count <= '0;
    end else begin
      r_slots <= w_next;
      r_count <= w_count;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && i_release) begin
      assert (r_slots[i_release_id].valid)
        else $error("dc slot table: response for idle slot %0d", i_release_id);
    end
  end

endmodule

// File: rtl/dcache_port_arbiter.sv
// Shares the D-cache request port between load-queue loads and store-queue drains, routing load responses back by slot ID.
module dcache_port_arbiter
  import dcache_port_arbiter_pkg::*;
#(
  parameter int LQ_SIZE         = DC_LQ_SIZE,
  parameter int MAX_OUTSTANDING = DC_MAX_OUTSTANDING,
  parameter int STARVE_LIMIT    = 4
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic                                 lq_req_valid,
  input  logic [ADDR_W-1:0]                    lq_req_addr,
  input  logic [MEM_SIZE_W-1:0]                lq_req_size,
  input  logic [$clog2(LQ_SIZE)-1:0]           lq_req_tag,
  output logic                                 lq_req_accept,
  input  logic                                 sq_req_valid,
  input  logic [ADDR_W-1:0]                    sq_req_addr,
  input  logic [MEM_SIZE_W-1:0]                sq_req_size,
  input  logic [MEM_BLOCK_W-1:0]               sq_req_data,
  input  logic                                 sq_drain_urgent,
  output logic                                 sq_req_accept,
  output logic                                 dc_req_valid,
  output logic                                 dc_req_cmd,
  output logic [ADDR_W-1:0]                    dc_req_addr,
  output logic [MEM_SIZE_W-1:0]                dc_req_size,
  output logic [MEM_BLOCK_W-1:0]               dc_req_data,
  output logic [$clog2(MAX_OUTSTANDING)-1:0]   dc_req_id,
  input  logic                                 dc_req_ready,
  input  logic                                 dc_rsp_valid,
  input  logic [$clog2(MAX_OUTSTANDING)-1:0]   dc_rsp_id,
  input  logic [MEM_BLOCK_W-1:0]               dc_rsp_data,
  output logic                                 lq_rsp_valid,
  output logic [$clog2(LQ_SIZE)-1:0]           lq_rsp_tag,
  output logic [MEM_BLOCK_W-1:0]               lq_rsp_data,
  input  logic                                 squash,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_cnt,
  output logic                                 o_dbg_state
);

  localparam int LQ_IDX_W = $clog2(LQ_SIZE);
  localparam int ID_W     = $clog2(MAX_OUTSTANDING);
  localparam int SC_W     = $clog2(STARVE_LIMIT + 1);

  arb_state_e          r_state;
  logic [SC_W-1:0]     r_starve_cnt;

  logic                w_free_avail;
  logic [ID_W-1:0]     w_free_id;
  logic                w_rel_valid;
  logic                w_rel_squashed;
  logic [LQ_IDX_W-1:0] w_rel_tag;
  logic                w_load_elig;
  logic                w_store_first;
  logic                w_pick_store;
  logic                w_pick_load;
  logic                w_store_lose;
  logic                w_rsp_deliver;

  // Urgency lifts stores ahead combinationally, so the very first urgent cycle already goes to the store.
  assign w_load_elig   = lq_req_valid && w_free_avail && !squash;
  assign w_store_first = sq_drain_urgent || (r_state == ARB_STORE_PRI);
  assign w_pick_store  = sq_req_valid && (w_store_first || !w_load_elig);
  assign w_pick_load   = w_load_elig && !w_pick_store;
  assign w_store_lose  = sq_req_valid && w_pick_load;

  assign lq_req_accept = w_pick_load && dc_req_ready;
  assign sq_req_accept = w_pick_store && dc_req_ready;
  assign o_dbg_state   = r_state;

  always_comb begin
    dc_req_valid = w_pick_load || w_pick_store;
    dc_req_cmd   = MEM_LOAD;
    dc_req_addr  = '0;
    dc_req_size  = '0;
    dc_req_data  = '0;
    dc_req_id    = '0;
    if (w_pick_store) begin
      dc_req_cmd  = MEM_STORE;
      dc_req_addr = sq_req_addr;
      dc_req_size = sq_req_size;
      dc_req_data = sq_req_data;
    end else if (w_pick_load) begin
      dc_req_addr = lq_req_addr;
      dc_req_size = lq_req_size;
      dc_req_id   = w_free_id;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= ARB_LOAD_PRI;
      r_starve_cnt <= '0;
    end else begin
      case (r_state)
        ARB_LOAD_PRI: begin
          if (sq_req_accept || !sq_req_valid) r_starve_cnt <= '0;
          else if (w_store_lose && r_starve_cnt < SC_W'(STARVE_LIMIT - 1))
            r_starve_cnt <= r_starve_cnt + SC_W'(1);
          if (sq_req_valid && (sq_drain_urgent ||
              (w_store_lose && r_starve_cnt == SC_W'(STARVE_LIMIT - 1))))
            r_state <= ARB_STORE_PRI;
        end
        ARB_STORE_PRI: begin
          if (!sq_req_valid) begin
            r_state      <= ARB_LOAD_PRI;
            r_starve_cnt <= '0;
          end else if (sq_req_accept) begin
            r_starve_cnt <= '0;
            if (!sq_drain_urgent) r_state <= ARB_LOAD_PRI;
          end
        end
        default: r_state <= ARB_LOAD_PRI;
      endcase
    end
  end

  // Responses for squashed slots, or arriving during a squash, free the slot but never reach the LQ.
  assign w_rsp_deliver = dc_rsp_valid && w_rel_valid && !w_rel_squashed && !squash;

  always_ff @(posedge clock) begin
    if (reset) begin
      lq_rsp_valid <= 1'b0;
      lq_rsp_tag   <= '0;
      lq_rsp_data  <= '0;
    end else begin
      lq_rsp_valid <= w_rsp_deliver;
      if (w_rsp_deliver) begin
        lq_rsp_tag  <= w_rel_tag;
        lq_rsp_data <= dc_rsp_data;
      end
    end
  end

  dcache_port_arbiter_slot_table #(
    .N_SLOTS (MAX_OUTSTANDING)
  ) u_slot_table (
    .clock          (clock),
    .reset          (reset),
    .i_alloc        (lq_req_accept),
    .i_alloc_tag    (lq_req_tag),
    .i_release      (dc_rsp_valid),
    .i_release_id   (dc_rsp_id),
    .i_squash       (squash),
    .o_free_avail   (w_free_avail),
    .o_free_id      (w_free_id),
    .o_rel_valid    (w_rel_valid),
    .o_rel_squashed (w_rel_squashed),
    .o_rel_tag      (w_rel_tag),
    .o_count        (outstanding_cnt)
  );

endmodule

// File: tb/tb_dcache_port_arbiter.sv
// Directed bench for dcache_port_arbiter: grants, slot exhaustion, starvation, urgency, squash and out-of-order responses.
module tb_dcache_port_arbiter;
  import dcache_port_arbiter_pkg::*;

  logic        clock;
  logic        reset;
  logic        lq_req_valid;
  logic [31:0] lq_req_addr;
  logic [1:0]  lq_req_size;
  logic [6:0]  lq_req_tag;
  logic        lq_req_accept;
  logic        sq_req_valid;
  logic [31:0] sq_req_addr;
  logic [1:0]  sq_req_size;
  logic [63:0] sq_req_data;
  logic        sq_drain_urgent;
  logic        sq_req_accept;
  logic        dc_req_valid;
  logic        dc_req_cmd;
  logic [31:0] dc_req_addr;
  logic [1:0]  dc_req_size;
  logic [63:0] dc_req_data;
  logic [1:0]  dc_req_id;
  logic        dc_req_ready;
  logic        dc_rsp_valid;
  logic [1:0]  dc_rsp_id;
  logic [63:0] dc_rsp_data;
  logic        lq_rsp_valid;
  logic [6:0]  lq_rsp_tag;
  logic [63:0] lq_rsp_data;
  logic        squash;
  logic [2:0]  outstanding_cnt;
  logic        o_dbg_state;

  int total = 0;
  int bad   = 0;
  logic [6:0] exp_q[$];

  dcache_port_arbiter dut (
    .clock(clock), .reset(reset),
    .lq_req_valid(lq_req_valid), .lq_req_addr(lq_req_addr), .lq_req_size(lq_req_size),
    .lq_req_tag(lq_req_tag), .lq_req_accept(lq_req_accept),
    .sq_req_valid(sq_req_valid), .sq_req_addr(sq_req_addr), .sq_req_size(sq_req_size),
    .sq_req_data(sq_req_data), .sq_drain_urgent(sq_drain_urgent), .sq_req_accept(sq_req_accept),
    .dc_req_valid(dc_req_valid), .dc_req_cmd(dc_req_cmd), .dc_req_addr(dc_req_addr),
    .dc_req_size(dc_req_size), .dc_req_data(dc_req_data), .dc_req_id(dc_req_id),
    .dc_req_ready(dc_req_ready), .dc_rsp_valid(dc_rsp_valid), .dc_rsp_id(dc_rsp_id),
    .dc_rsp_data(dc_rsp_data), .lq_rsp_valid(lq_rsp_valid), .lq_rsp_tag(lq_rsp_tag),
    .lq_rsp_data(lq_rsp_data), .squash(squash), .outstanding_cnt(outstanding_cnt),
    .o_dbg_state(o_dbg_state)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    lq_req_valid = 0; lq_req_addr = '0; lq_req_size = '0; lq_req_tag = '0;
    sq_req_valid = 0; sq_req_addr = '0; sq_req_size = '0; sq_req_data = '0;
    sq_drain_urgent = 0; dc_req_ready = 0; dc_rsp_valid = 0; dc_rsp_id = '0;
    dc_rsp_data = '0; squash = 0;
  endtask

  task automatic test_reset();
    idle();
    reset = 1;
    repeat (2) cyc();
    reset = 0;
    total++; if (lq_rsp_valid !== 1'b0) begin bad++; $display("FAIL rst_rsp_valid got=%0b exp=0", lq_rsp_valid); end
    total++; if (lq_rsp_tag !== 7'd0) begin bad++; $display("FAIL rst_rsp_tag got=%0d exp=0", lq_rsp_tag); end
    total++; if (lq_rsp_data !== 64'd0) begin bad++; $display("FAIL rst_rsp_data got=%0h exp=0", lq_rsp_data); end
    total++; if (outstanding_cnt !== 3'd0) begin bad++; $display("FAIL rst_cnt got=%0d exp=0", outstanding_cnt); end
    total++; if (o_dbg_state !== ARB_LOAD_PRI) begin bad++; $display("FAIL rst_state got=%0b exp=0", o_dbg_state); end
    #2;
    total++; if (dc_req_valid !== 1'b0) begin bad++; $display("FAIL rst_dc_valid got=%0b exp=0", dc_req_valid); end
    // fill one slot, then squash together with reset: reset must leave the table empty
    lq_req_valid = 1; lq_req_tag = 7'd40; dc_req_ready = 1;
    cyc();
    lq_req_valid = 0; squash = 1; reset = 1;
    cyc();
    squash = 0; reset = 0;
    total++; if (outstanding_cnt !== 3'd0) begin bad++; $display("FAIL rst_squash_cnt got=%0d exp=0", outstanding_cnt); end
    idle();
  endtask

  task automatic test_single_load();
    idle();
    lq_req_valid = 1; lq_req_tag = 7'd5; lq_req_addr = 32'h100; lq_req_size = 2'd2;
    #2;
    total++; if (lq_req_accept !== 1'b0) begin bad++; $display("FAIL sl_not_ready_acc got=%0b exp=0", lq_req_accept); end
    total++; if (dc_req_valid !== 1'b1) begin bad++; $display("FAIL sl_not_ready_valid got=%0b exp=1", dc_req_valid); end
    cyc();
    total++; if (outstanding_cnt !== 3'd0) begin bad++; $display("FAIL sl_not_ready_cnt got=%0d exp=0", outstanding_cnt); end
    dc_req_ready = 1;
    #2;
    total++; if (lq_req_accept !== 1'b1) begin bad++; $display("FAIL sl_accept got=%0b exp=1", lq_req_accept); end
    total++; if (dc_req_id !== 2'd0) begin bad++; $display("FAIL sl_id got=%0d exp=0", dc_req_id); end
    total++; if (dc_req_cmd !== MEM_LOAD) begin bad++; $display("FAIL sl_cmd got=%0b exp=0", dc_req_cmd); end
    total++; if (dc_req_addr !== 32'h100) begin bad++; $display("FAIL sl_addr got=%0h exp=100", dc_req_addr); end
    total++; if (dc_req_size !== 2'd2) begin bad++; $display("FAIL sl_size got=%0d exp=2", dc_req_size); end
    total++; if (dc_req_data !== 64'd0) begin bad++; $display("FAIL sl_data got=%0h exp=0", dc_req_data); end
    cyc();
    lq_req_valid = 0;
    total++; if (outstanding_cnt !== 3'd1) begin bad++; $display("FAIL sl_cnt1 got=%0d exp=1", outstanding_cnt); end
    dc_rsp_valid = 1; dc_rsp_id = 2'd0; dc_rsp_data = 64'hDEAD;
    cyc();
    dc_rsp_valid = 0;
    total++; if (lq_rsp_valid !== 1'b1) begin bad++; $display("FAIL sl_rsp_valid got=%0b exp=1", lq_rsp_valid); end
    total++; if (lq_rsp_tag !== 7'd5) begin bad++; $display("FAIL sl_rsp_tag got=%0d exp=5", lq_rsp_tag); end
    total++; if (lq_rsp_data !== 64'hDEAD) begin bad++; $display("FAIL sl_rsp_data got=%0h exp=dead", lq_rsp_data); end
    total++; if (outstanding_cnt !== 3'd0) begin bad++; $display("FAIL sl_cnt0 got=%0d exp=0", outstanding_cnt); end
    cyc();
    total++; if (lq_rsp_valid !== 1'b0) begin bad++; $display("FAIL sl_rsp_pulse got=%0b exp=0", lq_rsp_valid); end
    idle();
  endtask

  task automatic test_slots_full();
    idle();
    dc_req_ready = 1; lq_req_valid = 1;
    for (int i = 0; i < 4; i++) begin
      lq_req_tag = 7'(10 + i);
      #2;
      total++; if (lq_req_accept !== 1'b1) begin bad++; $display("FAIL full_acc%0d got=%0b exp=1", i, lq_req_accept); end
      total++; if (dc_req_id !== 2'(i)) begin bad++; $display("FAIL full_id%0d got=%0d exp=%0d", i, dc_req_id, i); end
      cyc();
    end
    lq_req_tag = 7'd14;
    #2;
    total++; if (lq_req_accept !== 1'b0) begin bad++; $display("FAIL full_5th_acc got=%0b exp=0", lq_req_accept); end
    total++; if (dc_req_valid !== 1'b0) begin bad++; $display("FAIL full_5th_valid got=%0b exp=0", dc_req_valid); end
    total++; if (outstanding_cnt !== 3'd4) begin bad++; $display("FAIL full_cnt got=%0d exp=4", outstanding_cnt); end
    cyc();
    dc_rsp_valid = 1; dc_rsp_id = 2'd2; dc_rsp_data = 64'h22;
    #2;
    total++; if (lq_req_accept !== 1'b0) begin bad++; $display("FAIL full_same_cycle_acc got=%0b exp=0", lq_req_accept); end
    cyc();
    dc_rsp_valid = 0;
    total++; if (lq_rsp_tag !== 7'd12 || lq_rsp_valid !== 1'b1) begin bad++; $display("FAIL full_rsp2 got=%0b/%0d exp=1/12", lq_rsp_valid, lq_rsp_tag); end
    #2;
    total++; if (lq_req_accept !== 1'b1) begin bad++; $display("FAIL full_regrant_acc got=%0b exp=1", lq_req_accept); end
    total++; if (dc_req_id !== 2'd2) begin bad++; $display("FAIL full_regrant_id got=%0d exp=2", dc_req_id); end
    cyc();
    lq_req_valid = 0;
    total++; if (outstanding_cnt !== 3'd4) begin bad++; $display("FAIL full_cnt_again got=%0d exp=4", outstanding_cnt); end
    exp_q.push_back(7'd10); exp_q.push_back(7'd11); exp_q.push_back(7'd14); exp_q.push_back(7'd13);
    for (int i = 0; i < 4; i++) begin
      logic [6:0] e;
      dc_rsp_valid = 1; dc_rsp_id = 2'(i); dc_rsp_data = 64'(i);
      cyc();
      e = exp_q.pop_front();
      total++; if (lq_rsp_valid !== 1'b1 || lq_rsp_tag !== e) begin bad++; $display("FAIL drain_tag%0d got=%0b/%0d exp=1/%0d", i, lq_rsp_valid, lq_rsp_tag, e); end
    end
    dc_rsp_valid = 0;
    total++; if (outstanding_cnt !== 3'd0) begin bad++; $display("FAIL drain_cnt got=%0d exp=0", outstanding_cnt); end
    idle();
  endtask

  task automatic test_starvation();
    int ld_id[6]    = '{0, 1, 0, 1, 0, 0};
    bit rsp_v[6]    = '{0, 1, 1, 1, 1, 0};
    int rsp_id[6]   = '{0, 0, 1, 0, 1, 0};
    bit store_w[6]  = '{0, 0, 0, 0, 1, 0};
    idle();
    dc_req_ready = 1; lq_req_valid = 1; sq_req_valid = 1;
    sq_req_addr = 32'h200; sq_req_size = 2'd3; sq_req_data = 64'hCAFE;
    for (int c = 0; c < 6; c++) begin
      lq_req_tag = 7'(20 + c);
      dc_rsp_valid = rsp_v[c]; dc_rsp_id = 2'(rsp_id[c]); dc_rsp_data = 64'(c);
      #2;
      total++; if (sq_req_accept !== store_w[c]) begin bad++; $display("FAIL starve_sq_c%0d got=%0b exp=%0b", c, sq_req_accept, store_w[c]); end
      total++; if (lq_req_accept !== !store_w[c]) begin bad++; $display("FAIL starve_lq_c%0d got=%0b exp=%0b", c, lq_req_accept, !store_w[c]); end
      if (store_w[c]) begin
        total++; if (dc_req_cmd !== MEM_STORE || dc_req_data !== 64'hCAFE || dc_req_id !== 2'd0) begin bad++; $display("FAIL starve_store_fields got=%0b/%0h/%0d exp=1/cafe/0", dc_req_cmd, dc_req_data, dc_req_id); end
      end else begin
        total++; if (dc_req_id !== 2'(ld_id[c])) begin bad++; $display("FAIL starve_id_c%0d got=%0d exp=%0d", c, dc_req_id, ld_id[c]); end
      end
      cyc();
      if (c == 3) begin
        total++; if (o_dbg_state !== ARB_STORE_PRI) begin bad++; $display("FAIL starve_state got=%0b exp=1", o_dbg_state); end
      end
    end
    lq_req_valid = 0; sq_req_valid = 0;
    dc_rsp_valid = 1; dc_rsp_id = 2'd0;
    cyc();
    idle();
    total++; if (outstanding_cnt !== 3'd0) begin bad++; $display("FAIL starve_cnt_end got=%0d exp=0", outstanding_cnt); end
  endtask

  task automatic test_urgent();
    idle();
    dc_req_ready = 1; lq_req_valid = 1; lq_req_tag = 7'd30;
    sq_req_valid = 1; sq_req_data = 64'hBEEF; sq_drain_urgent = 1;
    for (int c = 0; c < 3; c++) begin
      #2;
      total++; if (sq_req_accept !== 1'b1 || lq_req_accept !== 1'b0) begin bad++; $display("FAIL urgent_c%0d got sq=%0b lq=%0b exp sq=1 lq=0", c, sq_req_accept, lq_req_accept); end
      cyc();
    end
    sq_drain_urgent = 0;
    #2;
    total++; if (sq_req_accept !== 1'b1) begin bad++; $display("FAIL urgent_release_sq got=%0b exp=1", sq_req_accept); end
    cyc();
    #2;
    total++; if (lq_req_accept !== 1'b1 || sq_req_accept !== 1'b0) begin bad++; $display("FAIL urgent_back_to_load got lq=%0b sq=%0b exp lq=1 sq=0", lq_req_accept, sq_req_accept); end
    cyc();
    lq_req_valid = 0; sq_req_valid = 0;
    dc_rsp_valid = 1; dc_rsp_id = 2'd0;
    cyc();
    idle();
  endtask

  task automatic test_squash();
    idle();
    dc_req_ready = 1; lq_req_valid = 1;
    for (int i = 0; i < 3; i++) begin
      lq_req_tag = 7'(1 + i);
      cyc();
    end
    total++; if (outstanding_cnt !== 3'd3) begin bad++; $display("FAIL sq_pre_cnt got=%0d exp=3", outstanding_cnt); end
    squash = 1; lq_req_tag = 7'd4;
    dc_rsp_valid = 1; dc_rsp_id = 2'd0; dc_rsp_data = 64'h11;
    #2;
    total++; if (lq_req_accept !== 1'b0) begin bad++; $display("FAIL squash_acc got=%0b exp=0", lq_req_accept); end
    total++; if (dc_req_valid !== 1'b0) begin bad++; $display("FAIL squash_dc_valid got=%0b exp=0", dc_req_valid); end
    cyc();
    squash = 0; lq_req_valid = 0;
    total++; if (lq_rsp_valid !== 1'b0 || outstanding_cnt !== 3'd2) begin bad++; $display("FAIL squash_cycle_rsp got=%0b/%0d exp=0/2", lq_rsp_valid, outstanding_cnt); end
    dc_rsp_id = 2'd1;
    cyc();
    total++; if (lq_rsp_valid !== 1'b0 || outstanding_cnt !== 3'd1) begin bad++; $display("FAIL squash_rsp1 got=%0b/%0d exp=0/1", lq_rsp_valid, outstanding_cnt); end
    dc_rsp_id = 2'd2;
    cyc();
    total++; if (lq_rsp_valid !== 1'b0 || outstanding_cnt !== 3'd0) begin bad++; $display("FAIL squash_rsp2 got=%0b/%0d exp=0/0", lq_rsp_valid, outstanding_cnt); end
    dc_rsp_valid = 0;
    lq_req_valid = 1; lq_req_tag = 7'd7;
    #2;
    total++; if (lq_req_accept !== 1'b1 || dc_req_id !== 2'd0) begin bad++; $display("FAIL squash_new_grant got=%0b/%0d exp=1/0", lq_req_accept, dc_req_id); end
    cyc();
    lq_req_valid = 0;
    dc_rsp_valid = 1; dc_rsp_id = 2'd0; dc_rsp_data = 64'h77;
    cyc();
    dc_rsp_valid = 0;
    total++; if (lq_rsp_valid !== 1'b1 || lq_rsp_tag !== 7'd7 || lq_rsp_data !== 64'h77) begin bad++; $display("FAIL squash_new_rsp got=%0b/%0d/%0h exp=1/7/77", lq_rsp_valid, lq_rsp_tag, lq_rsp_data); end
    idle();
  endtask

  task automatic test_out_of_order();
    idle();
    dc_req_ready = 1; lq_req_valid = 1;
    lq_req_tag = 7'd3;
    cyc();
    lq_req_tag = 7'd9;
    cyc();
    lq_req_valid = 0;
    dc_rsp_valid = 1; dc_rsp_id = 2'd1; dc_rsp_data = 64'h99;
    cyc();
    dc_rsp_id = 2'd0; dc_rsp_data = 64'h33;
    total++; if (lq_rsp_valid !== 1'b1 || lq_rsp_tag !== 7'd9 || lq_rsp_data !== 64'h99) begin bad++; $display("FAIL ooo_first got=%0b/%0d/%0h exp=1/9/99", lq_rsp_valid, lq_rsp_tag, lq_rsp_data); end
    cyc();
    dc_rsp_valid = 0;
    total++; if (lq_rsp_valid !== 1'b1 || lq_rsp_tag !== 7'd3 || lq_rsp_data !== 64'h33) begin bad++; $display("FAIL ooo_second got=%0b/%0d/%0h exp=1/3/33", lq_rsp_valid, lq_rsp_tag, lq_rsp_data); end
    cyc();
    total++; if (lq_rsp_valid !== 1'b0 || outstanding_cnt !== 3'd0) begin bad++; $display("FAIL ooo_end got=%0b/%0d exp=0/0", lq_rsp_valid, outstanding_cnt); end
    idle();
  endtask

  initial begin
    reset = 1;
    idle();
    test_reset();
    test_single_load();
    test_slots_full();
    test_starvation();
    test_urgent();
    test_squash();
    test_out_of_order();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
